// File: rtl/bus_dma_master_pkg.sv
// Shared bus definitions for the DMA master and other bus initiators:
// widths, byte-enable constant and the DMA controller state encoding.
package bus_dma_master_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam logic [3:0] BUS_MASK_FULL = 4'hF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    RD   = ST_RD,
    WR   = ST_WR,
    FIN  = ST_FIN,
    GAP  = ST_GAP
  } dma_state_e;

endpackage

// File: rtl/bus_master_drv.sv
// Tri-state drivers for one shared-bus initiator. Every line floats unless
// drive_en is high; data is driven only when data_oe is also high.
module bus_master_drv
  import bus_dma_master_pkg::*;
(
  input  logic                  drive_en,
  input  logic                  data_oe,
  input  logic [BUS_ADDR_W-1:0] addr,
  input  logic [BUS_DATA_W-1:0] wdata,
  input  logic                  rd,
  input  logic                  wr,
  output logic [BUS_DATA_W-1:0] rdata,
  inout  wire  [BUS_ADDR_W-1:0] addr_bus,
  inout  wire  [BUS_DATA_W-1:0] data_bus,
  inout  wire                   rd_bus,
  inout  wire                   wr_bus,
  inout  wire  [3:0]            data_mask_bus
);

  assign addr_bus      = drive_en ? addr : {BUS_ADDR_W{1'bz}};
  assign data_bus      = (drive_en && data_oe) ? wdata : {BUS_DATA_W{1'bz}};
  assign rd_bus        = drive_en ? rd : 1'bz;
  assign wr_bus        = drive_en ? wr : 1'bz;
  assign data_mask_bus = drive_en ? BUS_MASK_FULL : 4'bzzzz;
  assign rdata         = data_bus;

endmodule

// File: rtl/bus_dma_master.sv
// Bus-requesting DMA engine: copies word_count words from src to dst over the
// shared tri-state bus. Define BUS_DMA_FAIR_RELEASE_EN to drop dma_req for one
// cycle between words; otherwise the bus is held for the whole block.
module bus_dma_master
  import bus_dma_master_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BUS_ADDR_W-1:0] src_addr,
  input  logic [BUS_ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]      word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  dma_req,
  input  logic                  dma_grant,
  inout  wire  [BUS_ADDR_W-1:0] addr_bus,
  inout  wire  [BUS_DATA_W-1:0] data_bus,
  inout  wire                   rd_bus,
  inout  wire                   wr_bus,
  inout  wire  [3:0]            data_mask_bus,
  input  logic                  fc_bus
);

  dma_state_e state_reg, state_next;
  logic [BUS_ADDR_W-1:0] src_reg, dst_reg;
  logic [BUS_DATA_W-1:0] buf_reg, rdata;
  logic [CNT_W-1:0]      remaining_reg;
  logic                  pend_wr_reg;
  logic                  busy_reg, done_reg, req_reg;
  logic                  load, fetch, advance, lost;
  logic                  drive_en;

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    fetch      = 1'b0;
    advance    = 1'b0;
    lost       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = (word_count != '0);
          state_next = (word_count != '0) ? REQ : FIN;
        end
      end
      REQ: begin
        if (dma_grant) state_next = pend_wr_reg ? WR : RD;
      end
      RD: begin
        if (!dma_grant) begin
          lost       = 1'b1;
          state_next = REQ;
        end else if (fc_bus) begin
          fetch      = 1'b1;
          state_next = WR;
        end
      end
      WR: begin
        if (!dma_grant) begin
          lost       = 1'b1;
          state_next = REQ;
        end else if (fc_bus) begin
          advance = 1'b1;
          if (remaining_reg == CNT_W'(1)) state_next = FIN;
`ifdef BUS_DMA_FAIR_RELEASE_EN
          else state_next = GAP;
`else
          else state_next = RD;
`endif
        end
      end
      FIN:     state_next = IDLE;
      GAP:     state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      buf_reg       <= '0;
      remaining_reg <= '0;
      pend_wr_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      req_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        src_reg       <= src_addr;
        dst_reg       <= dst_addr;
        remaining_reg <= word_count;
        pend_wr_reg   <= 1'b0;
      end
      if (fetch) buf_reg <= rdata;
      // Remember which phase was cut off so the regrant resumes it exactly.
      if (lost) pend_wr_reg <= (state_reg == WR);
      if (advance) begin
        src_reg       <= src_reg + BUS_ADDR_W'(ADDR_STEP);
        dst_reg       <= dst_reg + BUS_ADDR_W'(ADDR_STEP);
        remaining_reg <= remaining_reg - CNT_W'(1);
        pend_wr_reg   <= 1'b0;
      end
      busy_reg <= (state_next == REQ) || (state_next == RD) ||
                  (state_next == WR)  || (state_next == GAP);
      done_reg <= (state_next == FIN);
      req_reg  <= (state_next == REQ) || (state_next == RD) || (state_next == WR);
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign dma_req = req_reg;

  // Combinational so the bus floats in the very cycle the grant is withdrawn.
  assign drive_en = dma_grant && ((state_reg == RD) || (state_reg == WR));

  bus_master_drv u_drv (
    .drive_en      (drive_en),
    .data_oe       (state_reg == WR),
    .addr          ((state_reg == RD) ? src_reg : dst_reg),
    .wdata         (buf_reg),
    .rd            (state_reg == RD),
    .wr            (state_reg == WR),
    .rdata         (rdata),
    .addr_bus      (addr_bus),
    .data_bus      (data_bus),
    .rd_bus        (rd_bus),
    .wr_bus        (wr_bus),
    .data_mask_bus (data_mask_bus)
  );

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: arbiter + slave environment on the falling edge,
// directed and random copies checked against an address/data reference list.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        dma_grant = 1'b0;
  logic        fc_bus = 1'b0;
  wire         busy, done, dma_req;
  wire  [31:0] addr_bus, data_bus;
  wire         rd_bus, wr_bus;
  wire  [3:0]  data_mask_bus;

  // Slave memory image: word at address a reads as rd_seed + (a - rd_base)/4.
  logic [31:0] rd_base = '0;
  logic [31:0] rd_seed = '0;
  wire  [31:0] slave_data = ((addr_bus - rd_base) >> 2) + rd_seed;
  assign data_bus = (rd_bus === 1'b1) ? slave_data : 32'bz;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int  rd_cnt, gap_cnt, cpu_grants, drop_word, drop_hold, gnt_wait, mask_bad;
  bit  drop_wr, dropped, req_seen, cpu_req;

  bus_dma_master dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .dma_req       (dma_req),
    .dma_grant     (dma_grant),
    .addr_bus      (addr_bus),
    .data_bus      (data_bus),
    .rd_bus        (rd_bus),
    .wr_bus        (wr_bus),
    .data_mask_bus (data_mask_bus),
    .fc_bus        (fc_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // An undriven line reads as z in a 4-state simulator and as 0 in a 2-state one.
  function automatic logic released();
    return (rd_bus !== 1'b1) && (wr_bus !== 1'b1) &&
           ((addr_bus === 32'bz) || (addr_bus === 32'h0)) && (data_mask_bus !== 4'hF);
  endfunction

  // Arbiter (grant 2 cycles after request, optional grant drop) and slave
  // (fc one cycle after each strobe, logging completed reads and writes).
  always @(negedge clk) begin
    bit rd_s, wr_s;
    logic [31:0] a_s, d_s;
    rd_s = (rd_bus === 1'b1);
    wr_s = (wr_bus === 1'b1);
    a_s  = addr_bus;
    d_s  = data_bus;
    fc_bus = 1'b0;
    if (busy && !dma_req) begin
      gap_cnt++;
      if (cpu_req) cpu_grants++;
    end
    if (dma_req) req_seen = 1'b1;
    if ((rd_s || wr_s) && data_mask_bus !== 4'hF) mask_bad++;
    if (!dma_req) begin
      dma_grant = 1'b0;
      gnt_wait  = 0;
    end else if (!dma_grant) begin
      if (drop_hold > 0) drop_hold--;
      else begin
        gnt_wait++;
        if (gnt_wait >= 2) begin
          dma_grant = 1'b1;
          gnt_wait  = 0;
        end
      end
    end else if (rd_s || wr_s) begin
      if (!dropped && drop_word == wr_addr_q.size() && drop_wr == wr_s) begin
        dma_grant = 1'b0;
        dropped   = 1'b1;
        drop_hold = 3;
        #1;
        check("drop_release", {31'd0, released()}, 32'd1);
      end else begin
        fc_bus = 1'b1;
        if (rd_s) rd_cnt++;
        if (wr_s) begin
          wr_addr_q.push_back(a_s);
          wr_data_q.push_back(d_s);
        end
      end
    end
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int restart, input int dword, input bit dwr);
    int cycles;
    int exp_gaps;
`ifdef BUS_DMA_FAIR_RELEASE_EN
    exp_gaps = (n > 0) ? n - 1 : 0;
`else
    exp_gaps = 0;
`endif
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_cnt = 0; gap_cnt = 0; cpu_grants = 0; mask_bad = 0;
    req_seen = 1'b0; dropped = 1'b0;
    drop_word = dword; drop_wr = dwr;
    rd_base = s;
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; src_addr = ~s; dst_addr = ~d; word_count = 16'hFFFF;
    check("busy_after_start", {31'd0, busy}, {31'd0, (n > 0)});
    cycles = 0;
    while (!done && cycles < 3000) begin
      start = (cycles == restart);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("write_count", wr_addr_q.size(), n);
    check("read_count", rd_cnt, n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], d + 32'(4 * i));
      check($sformatf("wr_data[%0d]", i), wr_data_q[i], rd_seed + 32'(i));
    end
    check("req_gaps", gap_cnt, exp_gaps);
    check("cpu_grants", cpu_grants, cpu_req ? exp_gaps : 0);
    check("mask_full", mask_bad, 0);
    if (n == 0) check("req_never", {31'd0, req_seen}, 32'd0);
    @(negedge clk);
    check("done_pulse_end", {31'd0, done}, 32'd0);
    check("req_low_after", {31'd0, dma_req}, 32'd0);
    check("bus_released_after", {31'd0, released()}, 32'd1);
    $display("copy src=%h dst=%h cnt=%0d writes=%0d reads=%0d gaps=%0d",
             s, d, n, wr_addr_q.size(), rd_cnt, gap_cnt);
  endtask

  initial begin
    int cycles;
    logic [31:0] s, d;
    int n, dw;
    drop_word = -1; drop_hold = 0; gnt_wait = 0; cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {31'd0, dma_req}, 32'd0);
    check("rst_bus", {31'd0, released()}, 32'd1);
    rst = 1'b1;

    rd_seed = 32'h1234_5678;
    run_copy(32'h100, 32'h200, 1, -1, -1, 1'b0);
    rd_seed = 32'hA;
    run_copy(32'h100, 32'h200, 3, -1, -1, 1'b0);
    run_copy(32'h100, 32'h200, 0, -1, -1, 1'b0);
    rd_seed = 32'hBEEF_0000;
    run_copy(32'h300, 32'h800, 3, -1, 1, 1'b1);
    run_copy(32'h340, 32'h900, 2, -1, 0, 1'b0);
    cpu_req = 1'b1;
    run_copy(32'h400, 32'hA00, 2, -1, -1, 1'b0);
    cpu_req = 1'b0;
    rd_seed = 32'h5555_0001;
    run_copy(32'hFFFF_FFF8, 32'hFFFF_FFF4, 4, 5, -1, 1'b0);

    // Reset in the middle of a read phase, then a clean copy.
    drop_word = -1; dropped = 1'b0;
    rd_base = 32'h600;
    @(negedge clk);
    src_addr = 32'h600; dst_addr = 32'hC00; word_count = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!(rd_bus === 1'b1) && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("rd_phase_seen", {31'd0, (rd_bus === 1'b1)}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_bus", {31'd0, released()}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_req", {31'd0, dma_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end
    rst = 1'b1;
    rd_seed = 32'h7777_0000;
    run_copy(32'h600, 32'hC00, 4, -1, -1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      s = ($urandom() & 32'hFFFF_FFFC) | 32'h10;
      d = ($urandom() & 32'hFFFF_FFFC) | 32'h10;
      n = int'($urandom_range(1, 5));
      dw = int'($urandom_range(0, 6)) - 1;
      rd_seed = $urandom();
      run_copy(s, d, n, int'($urandom_range(1, 8)), dw, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
